// File: rtl/sipo_rx.sv
// sipo_rx: MSB-first 40-bit serial-to-parallel receiver with valid/accept holding storage
//   Sclk           in   link clock, rising edge
//   Clear_n        in   synchronous active-low reset
//   InputSerial    in   serial data bit, MSB first
//   InReady        in   bit strobe; InputSerial valid while high
//   OutAccept      in   consumer ready
//   OutputParallel out  assembled word (head of holding storage)
//   OutValid       out  OutputParallel holds an unconsumed word
//   FrameError     out  one-cycle pulse on a truncated frame
//   Overrun        out  one-cycle pulse when a completed word is dropped
//   OverrunCount   out  saturating count of dropped words
//   Build macro SIPO_SKID_EN selects a 2-entry FIFO instead of a single holding register.
module sipo_rx #(
  parameter int WIDTH = 40,
  parameter int CNT_W = 6
) (
  input  logic             Sclk,
  input  logic             Clear_n,
  input  logic             InputSerial,
  input  logic             InReady,
  input  logic             OutAccept,
  output logic [WIDTH-1:0] OutputParallel,
  output logic             OutValid,
  output logic             FrameError,
  output logic             Overrun,
  output logic [7:0]       OverrunCount
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_word;
  logic             w_done, w_frame_err, w_push, w_drop;
  logic             r_ferr, r_ovr;
  logic [7:0]       r_ovc;
  assign w_word = {r_sh[WIDTH-2:0], InputSerial};
  always_ff @(posedge Sclk) begin
    if (!Clear_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sh    <= InReady ? w_word : r_sh;
    end
  end
  // A dropped strobe or the last bit both return the counter to zero.
  always_comb begin
    w_state_nx = (!InReady || w_done) ? IDLE : SHIFT;
    w_cnt_nx   = (!InReady || w_done) ? '0 : r_cnt + CNT_W'(1);
  end
  always_comb begin
    w_done      = InReady && (r_cnt == CNT_W'(WIDTH - 1));
    w_frame_err = !InReady && (r_state == SHIFT);
  end
`ifdef SIPO_SKID_EN
  logic [WIDTH-1:0] r_q0, r_q1, w_q0, w_q1;
  logic [1:0]       r_fill, w_fill_pp;
  logic             w_pop;
  // Pop first, then push into the first free slot of the post-pop queue.
  always_comb begin
    w_pop     = OutAccept && (r_fill != 2'd0);
    w_push    = w_done && ((r_fill != 2'd2) || w_pop);
    w_drop    = w_done && !w_push;
    w_fill_pp = r_fill - {1'b0, w_pop};
    w_q0      = (w_push && w_fill_pp == 2'd0) ? w_word : (w_pop ? r_q1 : r_q0);
    w_q1      = (w_push && w_fill_pp == 2'd1) ? w_word : r_q1;
  end
  always_ff @(posedge Sclk) begin
    if (!Clear_n) begin
      r_q0   <= '0;
      r_q1   <= '0;
      r_fill <= 2'd0;
    end else begin
      r_q0   <= w_q0;
      r_q1   <= w_q1;
      r_fill <= w_fill_pp + {1'b0, w_push};
    end
  end
  assign OutputParallel = r_q0;
  assign OutValid       = r_fill != 2'd0;
`else
  logic [WIDTH-1:0] r_data;
  logic             r_valid, w_acc;
  // An accept on the completion edge frees the register for the new word.
  always_comb begin
    w_acc  = OutAccept && r_valid;
    w_push = w_done && (!r_valid || w_acc);
    w_drop = w_done && !w_push;
  end
  always_ff @(posedge Sclk) begin
    if (!Clear_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_push ? w_word : r_data;
      r_valid <= w_push || (r_valid && !w_acc);
    end
  end
  assign OutputParallel = r_data;
  assign OutValid       = r_valid;
`endif
  always_ff @(posedge Sclk) begin
    if (!Clear_n) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      r_ovc  <= '0;
    end else begin
      r_ferr <= w_frame_err;
      r_ovr  <= w_drop;
      r_ovc  <= (w_drop && r_ovc != 8'hFF) ? r_ovc + 8'd1 : r_ovc;
    end
  end
  assign FrameError   = r_ferr;
  assign Overrun      = r_ovr;
  assign OverrunCount = r_ovc;
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: directed self-checking bench for sipo_rx
module tb_sipo_rx;
  logic        Sclk = 1'b0;
  logic        Clear_n = 1'b0;
  logic        InputSerial = 1'b0;
  logic        InReady = 1'b0;
  logic        OutAccept = 1'b0;
  logic [39:0] OutputParallel;
  logic        OutValid, FrameError, Overrun;
  logic [7:0]  OverrunCount;
  int          checks = 0;
  int          errors = 0;
  sipo_rx dut (
    .Sclk(Sclk), .Clear_n(Clear_n), .InputSerial(InputSerial), .InReady(InReady),
    .OutAccept(OutAccept), .OutputParallel(OutputParallel), .OutValid(OutValid),
    .FrameError(FrameError), .Overrun(Overrun), .OverrunCount(OverrunCount)
  );
  always #5 Sclk = ~Sclk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rdy, input logic b);
    InReady = rdy;
    InputSerial = b;
    @(posedge Sclk);
    @(negedge Sclk);
  endtask
  task automatic send(input logic [39:0] w, input int n);
    for (int i = 0; i < n; i++) step(1'b1, w[39-i]);
  endtask
  task automatic reset();
    Clear_n = 1'b0;
    step(1'b0, 1'b0);
    Clear_n = 1'b1;
  endtask
  initial begin
    @(negedge Sclk);
    reset();
    chk("rst_valid", 64'(OutValid), 64'd0);
    chk("rst_data", 64'(OutputParallel), 64'd0);
    chk("rst_ferr", 64'(FrameError), 64'd0);
    chk("rst_ovr", 64'(Overrun), 64'd0);
    chk("rst_ovc", 64'(OverrunCount), 64'd0);
    OutAccept = 1'b1;
    send(40'hA5_1234_5678, 40);
    chk("f1_valid", 64'(OutValid), 64'd1);
    chk("f1_data", 64'(OutputParallel), 64'hA5_1234_5678);
    step(1'b0, 1'b0);
    chk("f1_consumed", 64'(OutValid), 64'd0);
    chk("idle_no_ferr", 64'(FrameError), 64'd0);
    send(40'hFF_FFFF_FFFF, 17);
    step(1'b0, 1'b0);
    chk("trunc_ferr", 64'(FrameError), 64'd1);
    chk("trunc_valid", 64'(OutValid), 64'd0);
    step(1'b0, 1'b0);
    chk("trunc_ferr_once", 64'(FrameError), 64'd0);
    send(40'h00_0000_0001, 40);
    chk("after_trunc_valid", 64'(OutValid), 64'd1);
    chk("after_trunc_data", 64'(OutputParallel), 64'h00_0000_0001);
    step(1'b0, 1'b0);
    send(40'h12_3456_789A, 40);
    chk("b2b_w1_valid", 64'(OutValid), 64'd1);
    chk("b2b_w1_data", 64'(OutputParallel), 64'h12_3456_789A);
    send(40'hFE_DCBA_9876, 1);
    chk("b2b_w1_taken", 64'(OutValid), 64'd0);
    chk("b2b_no_ferr", 64'(FrameError), 64'd0);
    send(40'hFE_DCBA_9876 << 1, 39);
    chk("b2b_w2_valid", 64'(OutValid), 64'd1);
    chk("b2b_w2_data", 64'(OutputParallel), 64'hFE_DCBA_9876);
    step(1'b0, 1'b0);
    chk("b2b_drained", 64'(OutValid), 64'd0);
    reset();
    OutAccept = 1'b0;
    send(40'h11_1111_1111, 40);
    chk("ov_w1_valid", 64'(OutValid), 64'd1);
    chk("ov_w1_no_ovr", 64'(Overrun), 64'd0);
    step(1'b0, 1'b0);
    send(40'h22_2222_2222, 40);
`ifdef SIPO_SKID_EN
    chk("ov_w2_ovr", 64'(Overrun), 64'd0);
`else
    chk("ov_w2_ovr", 64'(Overrun), 64'd1);
`endif
    step(1'b0, 1'b0);
    chk("ov_pulse_once", 64'(Overrun), 64'd0);
    send(40'h33_3333_3333, 40);
    chk("ov_w3_ovr", 64'(Overrun), 64'd1);
`ifdef SIPO_SKID_EN
    chk("ov_count", 64'(OverrunCount), 64'd1);
`else
    chk("ov_count", 64'(OverrunCount), 64'd2);
`endif
    chk("ov_head", 64'(OutputParallel), 64'h11_1111_1111);
    OutAccept = 1'b1;
    step(1'b0, 1'b0);
`ifdef SIPO_SKID_EN
    chk("ov_second_valid", 64'(OutValid), 64'd1);
    chk("ov_second_data", 64'(OutputParallel), 64'h22_2222_2222);
    step(1'b0, 1'b0);
`endif
    chk("ov_drained", 64'(OutValid), 64'd0);
    OutAccept = 1'b0;
    send(40'h5A_5A5A_5A5A, 40);
    chk("mid_held", 64'(OutValid), 64'd1);
    send(40'hC3_C3C3_C3C3, 19);
    Clear_n = 1'b0;
    step(1'b1, 1'b1);
    Clear_n = 1'b1;
    chk("mid_rst_valid", 64'(OutValid), 64'd0);
    chk("mid_rst_data", 64'(OutputParallel), 64'd0);
    chk("mid_rst_ferr", 64'(FrameError), 64'd0);
    chk("mid_rst_ovc", 64'(OverrunCount), 64'd0);
    step(1'b0, 1'b0);
    chk("mid_rst_no_ferr", 64'(FrameError), 64'd0);
    OutAccept = 1'b1;
    send(40'h96_0F0F_F0F0, 40);
    chk("mid_rst_next_valid", 64'(OutValid), 64'd1);
    chk("mid_rst_next_data", 64'(OutputParallel), 64'h96_0F0F_F0F0);
    step(1'b0, 1'b0);
    OutAccept = 1'b0;
    send(40'h01_2345_6789, 40);
    send(40'hAB_CDEF_0123, 39);
    chk("coinc_hold_data", 64'(OutputParallel), 64'h01_2345_6789);
    OutAccept = 1'b1;
    step(1'b1, 1'b1);
    chk("coinc_valid", 64'(OutValid), 64'd1);
    chk("coinc_data", 64'(OutputParallel), 64'hAB_CDEF_0123);
    chk("coinc_no_ovr", 64'(Overrun), 64'd0);
    step(1'b0, 1'b0);
    chk("coinc_drained", 64'(OutValid), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
